nwcc_cycle_ctrl: RTL
====================

Name: nwcc_cycle_ctrl

Overview:
Measurement-cycle sequencer for the NWCC neutron coincidence datapath.
- Clears the datapath and opens a programmable counting gate on the pulse stream.
- Waits for the 8/128/1024 µs delay lines to drain, then captures the R+A, A and total counts.
- Hands each result to readout over a valid/ready handshake.
- Repeats for a programmed number of cycles.

Parameters:
- CNT_W, 13: width of the datapath count buses.
- LEN_W, 24: width of the gate length, in clk_1mhz cycles (µs).
- NCYC_W, 8: width of the cycle-count and cycle-index fields.
- CLR_CYC, 2: number of clocks dp_reset_op is held high in CLEAR.
- DRAIN_CYC, 1040: clocks spent in DRAIN after the gate closes; must be ≥ 1032 (8 + 1024 delay).
- ACC_W, 32: width of the run accumulators (optional feature only).

Ports:
- clk_1mhz  in  1  system clock, 1 MHz.
- reset_ip  in  1  asynchronous, active-high reset.
- start_ip  in  1  single-clock request to begin a run.
- abort_ip  in  1  single-clock request to cancel the run.
- cycle_len_ip  in  LEN_W  gate length in clocks.
- num_cycles_ip  in  NCYC_W  cycles per run.
- pulse_ip  in  1  raw detector pulse, synchronous to clk_1mhz.
- pulse_op  out  1  gated pulse to the datapath = pulse_ip & gate_op.
- gate_op  out  1  counting gate is open.
- dp_reset_op  out  1  drives the datapath reset.
- ra_count_ip, a_count_ip, total_count_ip  in  CNT_W  datapath results.
- out_valid_op  out  1  result available.
- out_ready_ip  in  1  readout accepts the result.
- out_ra_op, out_a_op, out_total_op  out  CNT_W  captured results.
- out_ovf_op  out  1  pulse overflow occurred in this cycle.
- cycle_idx_op  out  NCYC_W  index of the current cycle, 0-based.
- busy_op  out  1  a run is in progress.
- done_op  out  1  single-clock pulse at normal completion of a run.
- acc_ra_op, acc_a_op, acc_total_op  out  ACC_W  run accumulators.

Behaviour:
- Reset (asynchronous): all outputs and registers go to 0; state = IDLE.
- States: IDLE, CLEAR, COUNT, DRAIN, CAPTURE, REPORT, DONE.
- IDLE:
  - On start_ip: latch cycle_len_ip and num_cycles_ip; a value of 0 in either is treated as 1.
  - Clear cycle_idx; go to CLEAR.
- CLEAR: dp_reset_op = 1 for exactly CLR_CYC clocks; gate_op = 0; then go to COUNT.
- COUNT: gate_op = 1 for exactly the latched length in clocks; then go to DRAIN.
- Overflow detection:
  - An internal saturating counter of width CNT_W+1 counts pulse_op during COUNT.
  - ovf is set when this counter reaches 2^CNT_W.
  - The counter and ovf are cleared in CLEAR.
- DRAIN: gate_op = 0 for DRAIN_CYC clocks; then go to CAPTURE.
- CAPTURE (1 clock):
  - Register ra/a/total inputs and ovf into the out_* registers.
  - out_valid_op = 1 from the next clock; go to REPORT.
- REPORT:
  - out_valid_op and the out_* values stay stable until out_ready_ip is sampled high.
  - On handshake: out_valid_op = 0 next clock.
  - If cycle_idx+1 == num_cycles, go to DONE; otherwise increment cycle_idx and go to CLEAR.
- DONE: done_op = 1 for 1 clock; go to IDLE.
- busy_op = 1 in every state except IDLE.
- Latency: start_ip to first out_valid_op = CLR_CYC + len + DRAIN_CYC + 2 clocks.
- abort_ip:
  - In any non-IDLE state: next state is IDLE.
  - gate_op, dp_reset_op and out_valid_op go to 0 next clock; done_op is not pulsed.
  - out_* registers keep their last values.
- start_ip while not in IDLE: ignored.
- start_ip and abort_ip high together in IDLE: abort wins, start is ignored.
- pulse_op is combinational, so there is zero added latency on the pulse path.
- cycle_idx does not wrap within a run, since its limit is num_cycles ≤ 2^NCYC_W−1.

Optional Feature:
NWCC_ACCUM_EN
- Defined:
  - At each REPORT handshake, add out_ra/out_a/out_total, zero-extended, into acc_*_op.
  - Accumulators clear on start_ip accepted in IDLE and on reset.
  - Sums wrap modulo 2^ACC_W.
- Undefined: acc_*_op are tied to 0 and no accumulator registers exist.

Test Plan:
- Basic cycle: len=100, num=1, 10 pulses 20 clocks apart inside the gate.
  - dp_reset_op high 2 clocks; gate_op high exactly 100 clocks.
  - out_valid_op at start+1144; out_total_op=10; done_op pulses once after the handshake.
- Backpressure: out_ready_ip held low 50 clocks after valid.
  - out_valid_op and the out_* values are stable throughout.
  - No dp_reset_op, and cycle_idx_op unchanged, until the handshake.
- Multi-cycle: num=3, len=10, ready tied high.
  - Three handshakes with cycle_idx_op = 0, 1, 2.
  - One done_op pulse; busy_op falls in the same clock as done_op leaves DONE.
- Abort in COUNT at gate clock 5: gate_op=0 and busy_op=0 next clock; no out_valid_op, no done_op; a later start_ip runs normally.
- Overflow boundary:
  - 8191 pulses in gate (len=8200, pulse every clock for 8191 clocks): out_ovf_op=0.
  - 8192 pulses: out_ovf_op=1.
  - A following cycle with 0 pulses: out_ovf_op=0.
- Reset mid-REPORT and accumulate:
  - Assert reset_ip asynchronously: all outputs 0 immediately, state IDLE.
  - With NWCC_ACCUM_EN, num=2, totals 7 and 5: acc_total_op = 12.

Source files
------------

// File: rtl/nwcc_cycle_ctrl.sv
// NWCC measurement-cycle sequencer: clear datapath, gate pulses, drain delay lines,
// capture counts and hand them to readout. Run accumulators built with NWCC_ACCUM_EN.
module nwcc_cycle_ctrl #(
    parameter int unsigned CNT_W     = 13,
    parameter int unsigned LEN_W     = 24,
    parameter int unsigned NCYC_W    = 8,
    parameter int unsigned CLR_CYC   = 2,
    parameter int unsigned DRAIN_CYC = 1040,
    parameter int unsigned ACC_W     = 32
) (
    input  logic              clk_1mhz,
    input  logic              reset_ip,
    input  logic              start_ip,
    input  logic              abort_ip,
    input  logic [LEN_W-1:0]  cycle_len_ip,
    input  logic [NCYC_W-1:0] num_cycles_ip,
    input  logic              pulse_ip,
    output logic              pulse_op,
    output logic              gate_op,
    output logic              dp_reset_op,
    input  logic [CNT_W-1:0]  ra_count_ip,
    input  logic [CNT_W-1:0]  a_count_ip,
    input  logic [CNT_W-1:0]  total_count_ip,
    output logic              out_valid_op,
    input  logic              out_ready_ip,
    output logic [CNT_W-1:0]  out_ra_op,
    output logic [CNT_W-1:0]  out_a_op,
    output logic [CNT_W-1:0]  out_total_op,
    output logic              out_ovf_op,
    output logic [NCYC_W-1:0] cycle_idx_op,
    output logic              busy_op,
    output logic              done_op,
    output logic [ACC_W-1:0]  acc_ra_op,
    output logic [ACC_W-1:0]  acc_a_op,
    output logic [ACC_W-1:0]  acc_total_op
);
    localparam int unsigned PCNT_W = CNT_W + 1;
    localparam int unsigned DRN_W  = $clog2(DRAIN_CYC + 1);
    localparam int unsigned CLR_W  = $clog2(CLR_CYC + 1);
    localparam int unsigned MAX_A  = (LEN_W > DRN_W) ? LEN_W : DRN_W;
    localparam int unsigned TMR_W  = (MAX_A > CLR_W) ? MAX_A : CLR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_COUNT, S_DRAIN, S_CAPTURE, S_REPORT, S_DONE
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   timer;
    logic [LEN_W-1:0]   len_q;
    logic [NCYC_W-1:0]  num_q;
    logic [PCNT_W-1:0]  pcnt;

    // Gating is combinational so pulses reach the datapath with no added latency.
    assign pulse_op = pulse_ip & gate_op;

`ifndef NWCC_ACCUM_EN
    assign acc_ra_op    = '0;
    assign acc_a_op     = '0;
    assign acc_total_op = '0;
`endif

    always_ff @(posedge clk_1mhz or posedge reset_ip) begin
        if (reset_ip) begin
            state        <= S_IDLE;
            timer        <= '0;
            len_q        <= '0;
            num_q        <= '0;
            pcnt         <= '0;
            gate_op      <= 1'b0;
            dp_reset_op  <= 1'b0;
            out_valid_op <= 1'b0;
            out_ra_op    <= '0;
            out_a_op     <= '0;
            out_total_op <= '0;
            out_ovf_op   <= 1'b0;
            cycle_idx_op <= '0;
            busy_op      <= 1'b0;
            done_op      <= 1'b0;
`ifdef NWCC_ACCUM_EN
            acc_ra_op    <= '0;
            acc_a_op     <= '0;
            acc_total_op <= '0;
`endif
        end else begin
            // Saturating pulse counter; its MSB is the overflow flag.
            if (pulse_op && !pcnt[CNT_W]) begin
                pcnt <= pcnt + PCNT_W'(1);
            end

            if (abort_ip && state != S_IDLE) begin
                state        <= S_IDLE;
                gate_op      <= 1'b0;
                dp_reset_op  <= 1'b0;
                out_valid_op <= 1'b0;
                busy_op      <= 1'b0;
                done_op      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_ip && !abort_ip) begin
                            len_q        <= (cycle_len_ip == '0) ? LEN_W'(1) : cycle_len_ip;
                            num_q        <= (num_cycles_ip == '0) ? NCYC_W'(1) : num_cycles_ip;
                            cycle_idx_op <= '0;
                            timer        <= TMR_W'(CLR_CYC - 1);
                            dp_reset_op  <= 1'b1;
                            busy_op      <= 1'b1;
                            state        <= S_CLEAR;
`ifdef NWCC_ACCUM_EN
                            acc_ra_op    <= '0;
                            acc_a_op     <= '0;
                            acc_total_op <= '0;
`endif
                        end
                    end
                    S_CLEAR: begin
                        pcnt <= '0;
                        if (timer == '0) begin
                            dp_reset_op <= 1'b0;
                            gate_op     <= 1'b1;
                            timer       <= TMR_W'(len_q) - TMR_W'(1);
                            state       <= S_COUNT;
                        end else begin
                            timer <= timer - TMR_W'(1);
                        end
                    end
                    S_COUNT: begin
                        if (timer == '0) begin
                            gate_op <= 1'b0;
                            timer   <= TMR_W'(DRAIN_CYC - 1);
                            state   <= S_DRAIN;
                        end else begin
                            timer <= timer - TMR_W'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (timer == '0) begin
                            state <= S_CAPTURE;
                        end else begin
                            timer <= timer - TMR_W'(1);
                        end
                    end
                    S_CAPTURE: begin
                        out_ra_op    <= ra_count_ip;
                        out_a_op     <= a_count_ip;
                        out_total_op <= total_count_ip;
                        out_ovf_op   <= pcnt[CNT_W];
                        out_valid_op <= 1'b1;
                        state        <= S_REPORT;
                    end
                    S_REPORT: begin
                        if (out_ready_ip) begin
                            out_valid_op <= 1'b0;
`ifdef NWCC_ACCUM_EN
                            acc_ra_op    <= acc_ra_op + ACC_W'(out_ra_op);
                            acc_a_op     <= acc_a_op + ACC_W'(out_a_op);
                            acc_total_op <= acc_total_op + ACC_W'(out_total_op);
`endif
                            if (cycle_idx_op + NCYC_W'(1) == num_q) begin
                                done_op <= 1'b1;
                                state   <= S_DONE;
                            end else begin
                                cycle_idx_op <= cycle_idx_op + NCYC_W'(1);
                                timer        <= TMR_W'(CLR_CYC - 1);
                                dp_reset_op  <= 1'b1;
                                state        <= S_CLEAR;
                            end
                        end
                    end
                    S_DONE: begin
                        done_op <= 1'b0;
                        busy_op <= 1'b0;
                        state   <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
